// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing source for the display pipeline. Two segment FSMs (ACTIVE,
// FRONT, SYNC, BACK) track the horizontal and vertical position. The vertical
// FSM advances only when the horizontal counter wraps. Every output is
// registered and decoded from the next-state/next-count values. As a result,
// the coordinates and their qualifiers change on the same clk_i edge.
//
// Optional build macro: VTG_MAP_COORD_EN. When defined, the module adds the
// map-relative coordinates map_x_o/map_y_o. These are zero outside the map
// window.
//
// Ports:
//   clk_i             system clock
//   rst_i             synchronous active-high reset (priority over pix_ce_i)
//   pix_ce_i          pixel clock-enable; raster advances one pixel when high
//   hsync_o/vsync_o   sync outputs, active level given by SYNC_POL
//   display_enable_o  position is inside the active area
//   map_enable_o      position is inside the map window
//   pixel_x_o/_y_o    raw column/line counts (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   line_start_o      pixel_x_o == 0
//   frame_start_o     position == (0,0)
//   map_x_o/map_y_o   (VTG_MAP_COORD_EN only) position relative to map origin
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int MAP_X0   = 64,
    parameter int MAP_Y0   = 48,
    parameter int MAP_W    = 512,
    parameter int MAP_H    = 384,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL),
    localparam int MXW     = (MAP_W > 1) ? $clog2(MAP_W) : 1,
    localparam int MYW     = (MAP_H > 1) ? $clog2(MAP_H) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pix_ce_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          display_enable_o,
    output logic          map_enable_o,
    output logic [HW-1:0] pixel_x_o,
    output logic [VW-1:0] pixel_y_o,
    output logic          line_start_o,
`ifdef VTG_MAP_COORD_EN
    output logic          frame_start_o,
    output logic [MXW-1:0] map_x_o,
    output logic [MYW-1:0] map_y_o
`else
    output logic          frame_start_o
`endif
);

    // Reject configurations that cannot produce a sane raster.
    if ((MAP_X0 + MAP_W > H_ACTIVE) || (MAP_Y0 + MAP_H > V_ACTIVE)) begin : g_bad_map
        $error("video_timing_gen: map window exceeds the active area");
    end
    if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_porch
        $error("video_timing_gen: porch and sync widths must be non-zero");
    end

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } seg_t;

    // Last count of each segment, sized to the counter width.
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_FP_LAST   = HW'(H_ACTIVE + H_FP - 1);
    localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_FP_LAST   = VW'(V_ACTIVE + V_FP - 1);
    localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);

    localparam logic [HW-1:0] H_MAP_LO = HW'(MAP_X0);
    localparam logic [HW-1:0] H_MAP_HI = HW'(MAP_X0 + MAP_W);
    localparam logic [VW-1:0] V_MAP_LO = VW'(MAP_Y0);
    localparam logic [VW-1:0] V_MAP_HI = VW'(MAP_Y0 + MAP_H);

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    seg_t          r_h_state, r_v_state;
    seg_t          w_h_state_next, w_v_state_next;
    logic [HW-1:0] r_h_cnt, w_h_cnt_next;
    logic [VW-1:0] r_v_cnt, w_v_cnt_next;
    logic          w_h_wrap;

    logic r_hsync, r_vsync, r_de, r_me, r_ls, r_fs;
    logic w_hsync_next, w_vsync_next, w_de_next, w_me_next, w_ls_next, w_fs_next;
    logic w_in_map_x, w_in_map_y;

    // Next-state / next-count. The segment state steps on the last count of
    // its segment, so the state always agrees with the counter value.
    always_comb begin
        w_h_cnt_next   = r_h_cnt;
        w_v_cnt_next   = r_v_cnt;
        w_h_state_next = r_h_state;
        w_v_state_next = r_v_state;
        w_h_wrap       = 1'b0;

        if (pix_ce_i) begin
            if (r_h_cnt == H_LAST) begin
                w_h_cnt_next = '0;
                w_h_wrap     = 1'b1;
            end else begin
                w_h_cnt_next = r_h_cnt + HW'(1);
            end

            case (r_h_state)
                ST_ACTIVE: if (r_h_cnt == H_ACT_LAST)  w_h_state_next = ST_FRONT;
                ST_FRONT:  if (r_h_cnt == H_FP_LAST)   w_h_state_next = ST_SYNC;
                ST_SYNC:   if (r_h_cnt == H_SYNC_LAST) w_h_state_next = ST_BACK;
                ST_BACK:   if (r_h_cnt == H_LAST)      w_h_state_next = ST_ACTIVE;
                default:                               w_h_state_next = ST_BACK;
            endcase

            if (w_h_wrap) begin
                if (r_v_cnt == V_LAST) begin
                    w_v_cnt_next = '0;
                end else begin
                    w_v_cnt_next = r_v_cnt + VW'(1);
                end

                case (r_v_state)
                    ST_ACTIVE: if (r_v_cnt == V_ACT_LAST)  w_v_state_next = ST_FRONT;
                    ST_FRONT:  if (r_v_cnt == V_FP_LAST)   w_v_state_next = ST_SYNC;
                    ST_SYNC:   if (r_v_cnt == V_SYNC_LAST) w_v_state_next = ST_BACK;
                    ST_BACK:   if (r_v_cnt == V_LAST)      w_v_state_next = ST_ACTIVE;
                    default:                               w_v_state_next = ST_BACK;
                endcase
            end
        end
    end

    // Output decode from the next position, so registered qualifiers line
    // up with the registered coordinates.
    always_comb begin
        w_in_map_x   = (w_h_cnt_next >= H_MAP_LO) && (w_h_cnt_next < H_MAP_HI);
        w_in_map_y   = (w_v_cnt_next >= V_MAP_LO) && (w_v_cnt_next < V_MAP_HI);
        w_de_next    = (w_h_state_next == ST_ACTIVE) && (w_v_state_next == ST_ACTIVE);
        w_me_next    = w_de_next && w_in_map_x && w_in_map_y;
        w_hsync_next = (w_h_state_next == ST_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        w_vsync_next = (w_v_state_next == ST_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        w_ls_next    = (w_h_cnt_next == '0);
        w_fs_next    = (w_h_cnt_next == '0) && (w_v_cnt_next == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_h_cnt   <= H_LAST;
            r_v_cnt   <= V_LAST;
            r_h_state <= ST_BACK;
            r_v_state <= ST_BACK;
            r_hsync   <= ~SYNC_ACT;
            r_vsync   <= ~SYNC_ACT;
            r_de      <= 1'b0;
            r_me      <= 1'b0;
            r_ls      <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            // With pix_ce_i low the next values equal the current ones,
            // so an unconditional update holds everything.
            r_h_cnt   <= w_h_cnt_next;
            r_v_cnt   <= w_v_cnt_next;
            r_h_state <= w_h_state_next;
            r_v_state <= w_v_state_next;
            r_hsync   <= w_hsync_next;
            r_vsync   <= w_vsync_next;
            r_de      <= w_de_next;
            r_me      <= w_me_next;
            r_ls      <= w_ls_next;
            r_fs      <= w_fs_next;
        end
    end

    assign pixel_x_o        = r_h_cnt;
    assign pixel_y_o        = r_v_cnt;
    assign hsync_o          = r_hsync;
    assign vsync_o          = r_vsync;
    assign display_enable_o = r_de;
    assign map_enable_o     = r_me;
    assign line_start_o     = r_ls;
    assign frame_start_o    = r_fs;

`ifdef VTG_MAP_COORD_EN
    logic [MXW-1:0] r_map_x, w_map_x_next;
    logic [MYW-1:0] r_map_y, w_map_y_next;

    // Map-relative coordinates are forced to zero outside the map window.
    always_comb begin
        w_map_x_next = '0;
        w_map_y_next = '0;
        if (w_me_next) begin
            w_map_x_next = MXW'(w_h_cnt_next - H_MAP_LO);
            w_map_y_next = MYW'(w_v_cnt_next - V_MAP_LO);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_map_x <= '0;
            r_map_y <= '0;
        end else begin
            r_map_x <= w_map_x_next;
            r_map_y <= w_map_y_next;
        end
    end

    assign map_x_o = r_map_x;
    assign map_y_o = r_map_y;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances share the stimulus:
//   u_dut_a  default 640x480 timing (line-level and map-edge checks)
//   u_dut_b  small 24x18 raster, active-high sync (many full frames,
//            including vsync and wrap)
//
// On each negedge, the stimulus applies pix_ce/rst, advances a position model
// and pushes the expected outputs of both instances. A separate monitor pops
// one entry 1 ns after every posedge and compares it against the DUT pins.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    // Small-raster parameters for instance B.
    localparam int B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 3;
    localparam int B_VA = 12, B_VF = 2, B_VS = 2, B_VB = 2;
    localparam int B_MX0 = 4, B_MY0 = 3, B_MW = 8, B_MH = 6;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;   // 24
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;   // 18
    localparam int A_HT = 800, A_VT = 525;

    typedef struct packed {
        logic       hs, vs, de, me, ls, fs;
        logic [9:0] x, y;
        logic [8:0] mx, my;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
        int   tag;
        bit   adv;
        int   ax, ay;
    } txn_t;

    typedef struct {
        int   x, y;
        logic de, me, hs, ls, fs;
    } dir_t;

    logic clk = 1'b0;
    logic rst_in = 1'b1;
    logic pix_ce = 1'b0;

    logic       hs_a, vs_a, de_a, me_a, ls_a, fs_a;
    logic [9:0] px_a, py_a;
    logic       hs_b, vs_b, de_b, me_b, ls_b, fs_b;
    logic [4:0] px_b, py_b;
`ifdef VTG_MAP_COORD_EN
    logic [8:0] mx_a, my_a;
    logic [2:0] mx_b, my_b;
`endif

    always #5 clk = ~clk;

    video_timing_gen u_dut_a (
        .clk_i            (clk),
        .rst_i            (rst_in),
        .pix_ce_i         (pix_ce),
        .hsync_o          (hs_a),
        .vsync_o          (vs_a),
        .display_enable_o (de_a),
        .map_enable_o     (me_a),
        .pixel_x_o        (px_a),
        .pixel_y_o        (py_a),
        .line_start_o     (ls_a),
`ifdef VTG_MAP_COORD_EN
        .frame_start_o    (fs_a),
        .map_x_o          (mx_a),
        .map_y_o          (my_a)
`else
        .frame_start_o    (fs_a)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
        .SYNC_POL (1),
        .MAP_X0 (B_MX0), .MAP_Y0 (B_MY0), .MAP_W (B_MW), .MAP_H (B_MH)
    ) u_dut_b (
        .clk_i            (clk),
        .rst_i            (rst_in),
        .pix_ce_i         (pix_ce),
        .hsync_o          (hs_b),
        .vsync_o          (vs_b),
        .display_enable_o (de_b),
        .map_enable_o     (me_b),
        .pixel_x_o        (px_b),
        .pixel_y_o        (py_b),
        .line_start_o     (ls_b),
`ifdef VTG_MAP_COORD_EN
        .frame_start_o    (fs_b),
        .map_x_o          (mx_b),
        .map_y_o          (my_b)
`else
        .frame_start_o    (fs_b)
`endif
    );

    txn_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   ax, ay, bx, by;
    int   cnt_de_l0 = 0, cnt_hs_l0 = 0, cnt_fs_b = 0, exp_fs_b = 0;

    // Hand-computed points on the default raster: de, me, hsync level, ls, fs.
    dir_t dir_tab[14];
    initial begin
        dir_tab = '{
            '{  0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{639,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{640,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{655,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{656,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{751,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{752,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{799,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{  0,  1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
            '{ 64, 47, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{ 63, 48, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{ 64, 48, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{575, 48, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{576, 48, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}
        };
    end

    function automatic obs_t model_out(int x, int y, int ha, int hf, int hsw,
                                       int va, int vf, int vsw, bit pol,
                                       int mx0, int my0, int mw, int mh);
        obs_t o;
        bit   hact, vact;
        o      = '0;
        o.x    = 10'(x);
        o.y    = 10'(y);
        o.de   = (x < ha) && (y < va);
        hact   = (x >= ha + hf) && (x < ha + hf + hsw);
        vact   = (y >= va + vf) && (y < va + vf + vsw);
        o.hs   = hact ? pol : !pol;
        o.vs   = vact ? pol : !pol;
        o.me   = o.de && (x >= mx0) && (x < mx0 + mw) && (y >= my0) && (y < my0 + mh);
        o.ls   = (x == 0);
        o.fs   = (x == 0) && (y == 0);
`ifdef VTG_MAP_COORD_EN
        if (o.me) begin
            o.mx = 9'(x - mx0);
            o.my = 9'(y - my0);
        end
`endif
        return o;
    endfunction

    task automatic advance(inout int x, inout int y, input int ht, input int vt);
        if (x == ht - 1) begin
            x = 0;
            y = (y == vt - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
    endtask

    function automatic int find_tag(int x, int y);
        for (int i = 0; i < 14; i++)
            if (dir_tab[i].x == x && dir_tab[i].y == y) return i;
        return -1;
    endfunction

    // One clock of stimulus plus its expected result.
    task automatic step(input logic ce, input logic rst);
        txn_t t;
        @(negedge clk);
        pix_ce = ce;
        rst_in = rst;
        if (rst) begin
            ax = A_HT - 1; ay = A_VT - 1;
            bx = B_HT - 1; by = B_VT - 1;
        end else if (ce) begin
            advance(ax, ay, A_HT, A_VT);
            advance(bx, by, B_HT, B_VT);
            if (bx == 0 && by == 0) exp_fs_b++;
        end
        t.adv = ce && !rst;
        t.ax  = ax;
        t.ay  = ay;
        t.a   = model_out(ax, ay, 640, 16, 96, 480, 10, 2, 1'b0, 64, 48, 512, 384);
        t.b   = model_out(bx, by, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1'b1,
                          B_MX0, B_MY0, B_MW, B_MH);
        t.tag = t.adv ? find_tag(ax, ay) : -1;
        sb_q.push_back(t);
    endtask

    // Monitor: compare the DUT pins against the oldest expected entry.
    initial begin
        txn_t t;
        obs_t oa, ob;
        logic [4:0] dir_act, dir_exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                t  = sb_q.pop_front();
                oa = '0;
                ob = '0;
                oa.hs = hs_a; oa.vs = vs_a; oa.de = de_a; oa.me = me_a;
                oa.ls = ls_a; oa.fs = fs_a; oa.x = px_a; oa.y = py_a;
                ob.hs = hs_b; ob.vs = vs_b; ob.de = de_b; ob.me = me_b;
                ob.ls = ls_b; ob.fs = fs_b; ob.x = 10'(px_b); ob.y = 10'(py_b);
`ifdef VTG_MAP_COORD_EN
                oa.mx = mx_a; oa.my = my_a;
                ob.mx = 9'(mx_b); ob.my = 9'(my_b);
`endif
                total++;
                if (oa !== t.a) begin
                    bad++;
                    $display("FAIL rasterA at model (%0d,%0d): got x=%0d y=%0d hs=%b vs=%b de=%b me=%b ls=%b fs=%b mx=%0d my=%0d, need x=%0d y=%0d hs=%b vs=%b de=%b me=%b ls=%b fs=%b mx=%0d my=%0d",
                             t.ax, t.ay, oa.x, oa.y, oa.hs, oa.vs, oa.de, oa.me, oa.ls, oa.fs, oa.mx, oa.my,
                             t.a.x, t.a.y, t.a.hs, t.a.vs, t.a.de, t.a.me, t.a.ls, t.a.fs, t.a.mx, t.a.my);
                end
                total++;
                if (ob !== t.b) begin
                    bad++;
                    $display("FAIL rasterB: got x=%0d y=%0d hs=%b vs=%b de=%b me=%b ls=%b fs=%b mx=%0d my=%0d, need x=%0d y=%0d hs=%b vs=%b de=%b me=%b ls=%b fs=%b mx=%0d my=%0d",
                             ob.x, ob.y, ob.hs, ob.vs, ob.de, ob.me, ob.ls, ob.fs, ob.mx, ob.my,
                             t.b.x, t.b.y, t.b.hs, t.b.vs, t.b.de, t.b.me, t.b.ls, t.b.fs, t.b.mx, t.b.my);
                end
                if (t.tag >= 0) begin
                    dir_act = {de_a, me_a, hs_a, ls_a, fs_a};
                    dir_exp = {dir_tab[t.tag].de, dir_tab[t.tag].me, dir_tab[t.tag].hs,
                               dir_tab[t.tag].ls, dir_tab[t.tag].fs};
                    total++;
                    if (dir_act !== dir_exp) begin
                        bad++;
                        $display("FAIL point(%0d,%0d) {de,me,hs,ls,fs}: got %b need %b",
                                 dir_tab[t.tag].x, dir_tab[t.tag].y, dir_act, dir_exp);
                    end
                end
                if (t.adv && t.ay == 0) begin
                    if (de_a) cnt_de_l0++;
                    if (!hs_a) cnt_hs_l0++;
                end
                if (t.adv && fs_b) cnt_fs_b++;
            end
        end
    end

    initial begin
        int guard;
        ax = A_HT - 1; ay = A_VT - 1;
        bx = B_HT - 1; by = B_VT - 1;

        // Reset with the enable low, then with it high (reset has priority).
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // Pixel enable on every 4th clock: outputs hold between enables.
        for (int i = 0; i < 800; i++) step((i % 4) == 3, 1'b0);

        // Continuous enable up to the map edge lines of the default raster.
        guard = 0;
        while (!(ax == 700 && ay == 48) && guard < 60000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        total++;
        if (!(ax == 700 && ay == 48)) begin
            bad++;
            $display("FAIL reach_target: got guard=%0d need position (700,48)", guard);
        end

        // Irregular enable pattern.
        for (int i = 0; i < 500; i++) step(1'($urandom_range(0, 1)), 1'b0);

        // Mid-frame reset with the enable high, hold, then restart at (0,0).
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b0);

        step(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending need 0", sb_q.size());
        end
        // Line 0 of the default raster is traversed twice (once per reset).
        total++;
        if (cnt_de_l0 != 1280) begin
            bad++;
            $display("FAIL de_line0_count: got %0d need 1280", cnt_de_l0);
        end
        total++;
        if (cnt_hs_l0 != 192) begin
            bad++;
            $display("FAIL hsync_line0_count: got %0d need 192", cnt_hs_l0);
        end
        total++;
        if (cnt_fs_b != exp_fs_b || exp_fs_b == 0) begin
            bad++;
            $display("FAIL frame_start_b_count: got %0d need %0d", cnt_fs_b, exp_fs_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
